// File: rtl/fact_ctrl.sv
// Factorial sequencer: steers an external loadable down-counter and multiplies
// its successive values into a product register to form n! mod 2^P_WIDTH.
module fact_ctrl #(
  parameter int N_WIDTH = 8,
  parameter int P_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [N_WIDTH-1:0] n_in,
  input  logic [N_WIDTH-1:0] cnt_q,
  output logic               cnt_en,
  output logic               cnt_load,
  output logic [N_WIDTH-1:0] cnt_d,
  output logic               busy,
  output logic               done,
  output logic [P_WIDTH-1:0] result,
  output logic               ovf,
  output logic [1:0]         state_dbg
);

  // Handshake: go is a level request, accepted in any IDLE cycle where it is
  // high; acceptance loads the counter the same cycle. go is ignored while
  // busy, and done pulses for exactly one cycle before returning to IDLE.

  localparam int F_WIDTH = P_WIDTH + N_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [P_WIDTH-1:0] product;
  logic [F_WIDTH-1:0] full_prod;
  logic               start;
  logic               step;

  // Full-width multiply so the overflow bits are visible before truncation.
  assign full_prod = F_WIDTH'(product) * F_WIDTH'(cnt_q);

  assign cnt_d     = n_in;
  assign result    = product;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      product <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        product <= P_WIDTH'(1);
        ovf     <= 1'b0;
      end else if (step) begin
        product <= full_prod[P_WIDTH-1:0];
        ovf     <= ovf | (|full_prod[F_WIDTH-1:P_WIDTH]);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_load  = 1'b0;
    done      = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          cnt_en    = 1'b1;
          cnt_load  = 1'b1;
          start     = 1'b1;
          state_nxt = (n_in >= N_WIDTH'(2)) ? MUL : DONE;
        end
      end
      MUL: begin
        // A counter value of 1 contributes nothing, so it ends the run.
        if (cnt_q >= N_WIDTH'(2)) begin
          cnt_en = 1'b1;
          step   = 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl: drives it together with a loadable down-counter and
// checks cycle timing, counter sequence, result and overflow against a model.
module tb_fact_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic [7:0]  n_in;
  logic [7:0]  cnt_q = 8'h5a;
  logic        cnt_en;
  logic        cnt_load;
  logic [7:0]  cnt_d;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_result;
  logic        exp_ovf;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  fact_ctrl #(.N_WIDTH(8), .P_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .n_in(n_in), .cnt_q(cnt_q),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_d(cnt_d), .busy(busy),
    .done(done), .result(result), .ovf(ovf), .state_dbg(state_dbg)
  );

  // Down-counter: load or decrement when enabled; deliberately no reset.
  always @(posedge clk) begin
    if (cnt_en) cnt_q <= cnt_load ? cnt_d : cnt_q - 8'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // n! reduced mod 2^32 step by step; overflow if any step spilled past 32 bits.
  function automatic void fact_model(input int n, output logic [31:0] r, output logic o);
    longint unsigned p;
    longint unsigned f;
    p = 1;
    o = 1'b0;
    for (int k = n; k >= 2; k--) begin
      f = p * longint'(k);
      if ((f >> 32) != 0) o = 1'b1;
      p = f & 64'h0000_0000_FFFF_FFFF;
    end
    r = p[31:0];
  endfunction

  // Called at a negedge while the DUT is IDLE; returns at the negedge of the
  // first IDLE cycle after done, with go left high only when hold is set.
  task automatic run_fact(input int n, input bit hold, input int next_n);
    int c;
    go   = 1'b1;
    n_in = 8'(n);
    #1;
    check("accept_cnt_en", cnt_en, 1);
    check("accept_cnt_load", cnt_load, 1);
    check("accept_cnt_d", cnt_d, n);
    check("accept_busy", busy, 0);
    fact_model(n, exp_result, exp_ovf);
    for (int k = n; k >= 1; k--) exp_q.push_back(k);
    @(negedge clk);
    c = 1;
    while (n >= 2 && c <= n) begin
      go   = hold ? 1'b1 : 1'($urandom_range(0, 1));
      n_in = hold ? 8'(next_n) : 8'($urandom_range(0, 255));
      #1;
      check("mul_busy", busy, 1);
      check("mul_done", done, 0);
      check("mul_cnt_q", cnt_q, exp_q.pop_front());
      check("mul_cnt_en", cnt_en, (n - c + 1) >= 2);
      check("mul_cnt_load", cnt_load, 0);
      @(negedge clk);
      c++;
    end
    exp_q.delete();
    go   = hold ? 1'b1 : 1'($urandom_range(0, 1));
    n_in = hold ? 8'(next_n) : 8'($urandom_range(0, 255));
    #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_cnt_en", cnt_en, 0);
    @(negedge clk);
    go   = hold;
    n_in = 8'(next_n);
    #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_result", result, exp_result);
    check("idle_ovf", ovf, exp_ovf);
    check("idle_cnt_en", cnt_en, hold);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      go   = 1'b0;
      n_in = 8'($urandom_range(0, 255));
      #1;
      check("hold_result", result, exp_result);
      check("hold_ovf", ovf, exp_ovf);
      check("hold_busy", busy, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    n_in  = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt_en", cnt_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_fact(5, 0, 0);
    check("vec_5", result, 120);
    idle_cycles(1);
    run_fact(0, 0, 0);
    check("vec_0", result, 1);
    idle_cycles(1);
    run_fact(1, 0, 0);
    check("vec_1", result, 1);
    idle_cycles(1);
    run_fact(12, 0, 0);
    check("vec_12", result, 479001600);
    check("vec_12_ovf", ovf, 0);
    idle_cycles(1);
    run_fact(13, 0, 0);
    check("vec_13", result, 1932053504);
    check("vec_13_ovf", ovf, 1);
    idle_cycles(2);

    // go held high across an n=4 run, then n=9 accepted straight after done.
    run_fact(4, 1, 9);
    check("b2b_first", result, 24);
    run_fact(9, 0, 0);
    check("b2b_second", result, 362880);
    idle_cycles(1);

    // Reset asserted in cycle 3 of an n=6 run.
    go   = 1'b1;
    n_in = 8'd6;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_cnt_en", cnt_en, 0);
    @(negedge clk);
    run_fact(3, 0, 0);
    check("after_rst_3", result, 6);
    idle_cycles(1);

    for (int r = 0; r < 25; r++) begin
      run_fact(($urandom_range(0, 3) == 0) ? $urandom_range(14, 40) : $urandom_range(0, 13), 0, 0);
      idle_cycles($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
